// File: rtl/rx_filter_ctrl.sv
// rx_filter_ctrl: paces samples from a small input FIFO into a filter and
// serves filter coefficients from a double-buffered (active/shadow) store.
//
// Optional feature macro: RX_FILTER_CTRL_OVF_CNT_EN
//   When defined, adds output oovf_count, a 16-bit saturating count of
//   dropped pushes. Without it only the sticky ooverflow flag exists.
//
// FSM states:
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting; applies a pending bank swap, else issues if FIFO non-empty
//   ST_ISSUE | new sample on ofilt_sample, ofilt_new_sample high (one cycle)
//   ST_SPACE | enforcing minimum spacing, remembers an early isample_done
//   ST_DRAIN | spacing met, waiting for the filter's isample_done
//
// The head is popped on the edge that enters ST_ISSUE, so the sample and its
// pulse are both valid for the whole ISSUE cycle. SPACE holds SPACING-1
// cycles, giving an issue-to-issue interval of SPACING+1 clocks when the
// filter finishes inside SPACE. SPACING must be at least 2.
module rx_filter_ctrl #(
  parameter int SPACING    = 200,
  parameter int FIFO_DEPTH = 4,
  parameter int NTAPS      = 512
) (
  input  logic               crx_clk,
  input  logic               rrx_rst,
  input  logic               erx_en,
  input  logic signed [15:0] isample,
  input  logic               isample_valid,
  output logic               osample_ready,
  input  logic               icoef_wr_en,
  input  logic [8:0]         icoef_wr_addr,
  input  logic signed [15:0] icoef_wr_data,
  input  logic               icoef_swap,
  input  logic [8:0]         iselect_coefficient,
  output logic signed [15:0] ofilter_coefficient,
  output logic signed [15:0] ofilt_sample,
  output logic               ofilt_new_sample,
  input  logic               isample_done,
  output logic               obank,
  output logic               ooverflow,
  output logic               obusy
`ifdef RX_FILTER_CTRL_OVF_CNT_EN
  ,
  output logic [15:0]        oovf_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(SPACING + 1);
  localparam logic [CW-1:0] SPACE_LAST = CW'(SPACING - 2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_SPACE = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic done_seen_q, done_seen_d;
  logic issue_go;
  logic swap_apply;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [15:0]   fifo_mem [FIFO_DEPTH];
  logic          fifo_empty, fifo_full;
  logic          push, drop;

  logic [15:0] coef_mem [2][NTAPS];
  logic        wr_bank;
  logic [15:0] coef_q, coef_d;

  logic [15:0] sample_q, sample_d;
  logic        new_sample_q, new_sample_d;
  logic        bank_q, bank_d;
  logic        swap_pend_q, swap_pend_d;
  logic        ovf_q, ovf_d;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // A push into a full FIFO is still taken when the head leaves this cycle.
  assign push       = isample_valid && (!fifo_full || issue_go);
  assign drop       = isample_valid && fifo_full && !issue_go;
  assign wr_bank    = ~bank_q;

  // Next-state and sequencing decisions; everything freezes while erx_en is low.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_seen_d = done_seen_q;
    issue_go    = 1'b0;
    swap_apply  = 1'b0;
    if (erx_en) begin
      case (state_q)
        ST_IDLE: begin
          if (swap_pend_q) begin
            swap_apply = 1'b1;
          end else if (!fifo_empty) begin
            issue_go = 1'b1;
            state_d  = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt_d       = '0;
          done_seen_d = 1'b0;
          state_d     = ST_SPACE;
        end
        ST_SPACE: begin
          cnt_d       = cnt_q + CW'(1);
          done_seen_d = done_seen_q | isample_done;
          if (cnt_q == SPACE_LAST) begin
            state_d = (done_seen_q || isample_done) ? ST_IDLE : ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (isample_done) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath next values: FIFO pointers, issued sample, bank swap, overflow.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    sample_d     = sample_q;
    new_sample_d = issue_go;
    bank_d       = bank_q ^ swap_apply;
    swap_pend_d  = swap_apply ? 1'b0 : (swap_pend_q | icoef_swap);
    ovf_d        = ovf_q | drop;
    coef_d       = coef_mem[bank_q][iselect_coefficient];
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (issue_go) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      sample_d = fifo_mem[rd_ptr_q[AW-1:0]];
    end
  end

  // Control and output registers.
  always_ff @(posedge crx_clk or negedge rrx_rst) begin
    if (!rrx_rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      done_seen_q  <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      sample_q     <= '0;
      new_sample_q <= 1'b0;
      bank_q       <= 1'b0;
      swap_pend_q  <= 1'b0;
      ovf_q        <= 1'b0;
      coef_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      done_seen_q  <= done_seen_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      sample_q     <= sample_d;
      new_sample_q <= new_sample_d;
      bank_q       <= bank_d;
      swap_pend_q  <= swap_pend_d;
      ovf_q        <= ovf_d;
      coef_q       <= coef_d;
    end
  end

  // FIFO storage, not reset; the pointers define what is valid.
  always_ff @(posedge crx_clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q[AW-1:0]] <= isample;
    end
  end

  // Coefficient writes always land in the shadow bank as seen before any swap this cycle.
  always_ff @(posedge crx_clk) begin
    if (icoef_wr_en) begin
      coef_mem[wr_bank][icoef_wr_addr] <= icoef_wr_data;
    end
  end

`ifdef RX_FILTER_CTRL_OVF_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  // Saturating count of dropped pushes.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (drop && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_d = ovf_cnt_q + 16'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge crx_clk or negedge rrx_rst) begin
    if (!rrx_rst) begin
      ovf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign oovf_count = ovf_cnt_q;
`endif

  assign osample_ready       = !fifo_full;
  assign ofilter_coefficient = coef_q;
  assign ofilt_sample        = sample_q;
  assign ofilt_new_sample    = new_sample_q;
  assign obank               = bank_q;
  assign ooverflow           = ovf_q;
  assign obusy               = (state_q != ST_IDLE);

endmodule

// File: doc/rx_filter_ctrl.md
RX_FILTER_CTRL -- requirements
Module: rx_filter_ctrl

Interface
REQ-001 Parameter SPACING, default 200: minimum clocks between consecutive ofilt_new_sample pulses.
REQ-002 Parameter FIFO_DEPTH, default 4: input sample FIFO entries, power of two.
REQ-003 Parameter NTAPS, default 512: coefficients per bank, addressed by 9 bits.
REQ-004 crx_clk  in  1  sole clock, rising edge.
REQ-005 rrx_rst  in  1  reset, asynchronous, active-low.
REQ-006 erx_en  in  1  enable; low freezes FSM and counters, writes and FIFO pushes still accepted.
REQ-007 isample  in  16  signed incoming sample.
REQ-008 isample_valid  in  1  push isample when high and osample_ready high.
REQ-009 osample_ready  out  1  FIFO not full.
REQ-010 icoef_wr_en  in  1  write icoef_wr_data into the shadow bank.
REQ-011 icoef_wr_addr  in  9  shadow bank write address.
REQ-012 icoef_wr_data  in  16  signed coefficient.
REQ-013 icoef_swap  in  1  one-cycle request to exchange active and shadow banks.
REQ-014 iselect_coefficient  in  9  tap index requested by the filter.
REQ-015 ofilter_coefficient  out  16  active-bank coefficient at the requested index.
REQ-016 ofilt_sample  out  16  sample presented to the filter, held stable between pulses.
REQ-017 ofilt_new_sample  out  1  one-cycle pulse marking a new ofilt_sample.
REQ-018 isample_done  in  1  filter output-ready pulse.
REQ-019 obank  out  1  index of the active bank.
REQ-020 ooverflow  out  1  sticky: push attempted while FIFO full.
REQ-021 obusy  out  1  high in any state other than IDLE.

Function
REQ-022 Coefficient store: two banks of NTAPS x 16; writes always target the shadow bank (bank != obank).
REQ-023 ofilter_coefficient is registered: the value for iselect_coefficient sampled at edge N appears after edge N+1, so latency is 1 clock.
REQ-024 A write to the shadow bank and a read of the active bank in the same cycle at the same address do not interact.
REQ-025 icoef_swap sets a pending flag; a swap arriving while a swap is already pending is absorbed.
REQ-026 A pending swap toggles obank only in IDLE with no issue that cycle, so a sample is never filtered across mixed banks.
REQ-027 A write and an applied swap in the same cycle: the write lands in the pre-swap shadow bank.
REQ-028 FIFO: push on isample_valid && osample_ready; pop only on ISSUE; push and pop on the same cycle are both allowed when full.
REQ-029 A push while full is dropped and sets ooverflow, which stays set until reset.
REQ-030 FSM states: IDLE, ISSUE, SPACE, DRAIN.
REQ-031 IDLE -> ISSUE when erx_en is high, the FIFO is non-empty and no swap is pending; otherwise the pending swap is applied first.
REQ-032 ISSUE lasts one cycle: pop the head into ofilt_sample, pulse ofilt_new_sample, clear the spacing counter, go to SPACE.
REQ-033 SPACE counts to SPACING-1, then goes to DRAIN.
REQ-034 DRAIN waits for isample_done, then goes to IDLE.
REQ-035 If isample_done was seen during SPACE, DRAIN lasts zero cycles and SPACE goes straight to IDLE.
REQ-036 Back-to-back issue interval is exactly SPACING+1 clocks when isample_done arrives within SPACE.
REQ-037 isample_done in IDLE or ISSUE is ignored.

Reset
REQ-038 On rrx_rst low, asynchronously: state IDLE, FIFO empty, osample_ready 1, ofilt_sample 0, ofilt_new_sample 0, ofilter_coefficient 0, obank 0, swap pending 0, ooverflow 0, obusy 0.
REQ-039 Coefficient RAM contents are not reset.
REQ-040 Reset during SPACE or DRAIN abandons the in-flight sample and emits no pulse.

Configuration
REQ-041 With RX_FILTER_CTRL_OVF_CNT_EN defined, output oovf_count (16 bits) counts dropped pushes, saturates at 0xFFFF and resets to 0.
REQ-042 Without RX_FILTER_CTRL_OVF_CNT_EN, the oovf_count port and its counter do not exist and only ooverflow remains.

Verification
REQ-043 Reset, push 1,2,3 on consecutive cycles, isample_done 10 clocks after each pulse -> pulses carry 1,2,3, spaced 201 clocks apart.
REQ-044 Write addr 5 = 0x1234 to bank 1, swap, select 5 -> ofilter_coefficient 0x1234 one clock later, obank 1.
REQ-045 Swap asserted mid-SPACE -> obank unchanged until the return to IDLE and toggles before the next pulse.
REQ-046 Five pushes while the FSM is in SPACE (depth 4) -> 5th dropped, ooverflow 1, oovf_count 1 when the macro is defined.
REQ-047 isample_done withheld 300 clocks after a pulse -> FSM holds in DRAIN, no new pulse until done, then the next pulse 2 clocks later.
REQ-048 rrx_rst low at SPACE count 50 -> all outputs take reset values immediately, no pulse, and a push after release issues normally.
